// File: rtl/register_file_mp.sv
// register_file_mp
// Parametrised multi-port integer register file. Reads are registered (one
// cycle), an optional bypass forwards a same-edge write to a read of the same
// address, and write port 1 has priority over port 0 on an address collision.
// After reset a sequencer zeroes every entry, one per clock, so the storage
// needs no reset of its own and can map onto block RAM.
//
// Ports
//   i_clk       clock, all state updates on the rising edge
//   i_rst       synchronous reset, active low
//   o_ready     high once clearing has finished and requests are accepted
//   i_we        per write-port enable
//   i_rd        per write-port address
//   i_rd_data   per write-port data
//   i_re        per read-port enable
//   i_rs        per read-port address
//   o_rs_data   per read-port registered data (holds when not reading)
//   o_rs_valid  per read-port one-cycle strobe for an accepted read
module register_file_mp #(
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter bit BYPASS      = 1'b1,
    parameter bit ZERO_REG    = 1'b1,
    parameter int AW          = $clog2(NUM_REGS)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    output logic                                 o_ready,
    input  logic [WRITE_PORTS-1:0]               i_we,
    input  logic [WRITE_PORTS-1:0][AW-1:0]       i_rd,
    input  logic [WRITE_PORTS-1:0][XLEN-1:0]     i_rd_data,
    input  logic [READ_PORTS-1:0]                i_re,
    input  logic [READ_PORTS-1:0][AW-1:0]        i_rs,
    output logic [READ_PORTS-1:0][XLEN-1:0]      o_rs_data,
    output logic [READ_PORTS-1:0]                o_rs_valid
);

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e                            state_q;
    logic [AW-1:0]                     clr_cnt_q;
    logic                              ready_q;
    logic [READ_PORTS-1:0][XLEN-1:0]   rs_data_q;
    logic [READ_PORTS-1:0]             rs_valid_q;

    // Storage: no reset here; the sequencer is the only thing that clears it.
    logic [XLEN-1:0]                   mem_q [NUM_REGS];

    logic [WRITE_PORTS-1:0]            wr_in_range;
    logic [READ_PORTS-1:0]             rd_in_range;
    logic [WRITE_PORTS-1:0]            wr_eff;
    logic [READ_PORTS-1:0][XLEN-1:0]   rs_data_d;

    // Address range checks collapse to constants when NUM_REGS fills the
    // address space, which keeps the comparison out of the netlist entirely.
    generate
        if (NUM_REGS == (1 << AW)) begin : g_full_range
            always_comb begin
                wr_in_range = '1;
                rd_in_range = '1;
            end
        end else begin : g_partial_range
            always_comb begin
                wr_in_range = '0;
                rd_in_range = '0;
                for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                    wr_in_range[p] = (i_rd[p] < AW'(NUM_REGS));
                end
                for (int unsigned r = 0; r < READ_PORTS; r++) begin
                    rd_in_range[r] = (i_rs[r] < AW'(NUM_REGS));
                end
            end
        end
    endgenerate

    // A write is effective only in READY, in range, and not aimed at a
    // hardwired zero entry; only effective writes are stored or forwarded.
    always_comb begin
        wr_eff = '0;
        for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
            wr_eff[p] = (state_q == READY) && i_we[p] && wr_in_range[p] &&
                        !(ZERO_REG && (i_rd[p] == '0));
        end
    end

    // Read data selection. The write-port loop runs in ascending order so
    // port 1 overrides port 0 when both forward to the same address.
    always_comb begin
        rs_data_d = '0;
        for (int unsigned r = 0; r < READ_PORTS; r++) begin
            if (rd_in_range[r] && !(ZERO_REG && (i_rs[r] == '0))) begin
                rs_data_d[r] = mem_q[i_rs[r]];
            end
            if (BYPASS) begin
                for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                    if (wr_eff[p] && (i_rd[p] == i_rs[r])) begin
                        rs_data_d[r] = i_rd_data[p];
                    end
                end
            end
        end
    end

    // Storage writes: clearing sequencer in CLEAR, write ports in READY.
    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else begin
                for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
                    if (wr_eff[p]) begin
                        mem_q[i_rd[p]] <= i_rd_data[p];
                    end
                end
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            ready_q    <= 1'b0;
            rs_data_q  <= '0;
            rs_valid_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    rs_valid_q <= '0;
                    if (clr_cnt_q == AW'(NUM_REGS - 1)) begin
                        state_q   <= READY;
                        ready_q   <= 1'b1;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                READY: begin
                    for (int unsigned r = 0; r < READ_PORTS; r++) begin
                        rs_valid_q[r] <= i_re[r];
                        if (i_re[r]) begin
                            rs_data_q[r] <= rs_data_d[r];
                        end
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign o_ready    = ready_q;
    assign o_rs_data  = rs_data_q;
    assign o_rs_valid = rs_valid_q;

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file for the RV32 core. It generalises the current two-read, one-write register unit to configurable width, depth, read-port count and write-port count. It adds synchronous one-cycle reads with optional write-to-read bypass, deterministic multi-writer priority and a self-clearing reset sequencer, so block-RAM storage is zeroed without a single-cycle array reset. It sits between decode (read ports) and writeback (write ports); a superscalar or dual-issue pipeline uses WRITE_PORTS=2.

## Interface
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural entries; AW = $clog2(NUM_REGS).
- READ_PORTS, 2, number of read ports, 1..4.
- WRITE_PORTS, 1, number of write ports, 1..2.
- BYPASS, 1, 1 = a same-edge write is forwarded to a read of that address.
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero.
- i_clk  in  1  the single clock; all state updates on its rising edge.
- i_rst  in  1  synchronous, active-low reset.
- o_ready  out  1  high when clearing is done and requests are accepted.
- i_we  in  WRITE_PORTS  per-port write enable.
- i_rd  in  WRITE_PORTS x AW  per-port write address.
- i_rd_data  in  WRITE_PORTS x XLEN  per-port write data.
- i_re  in  READ_PORTS  per-port read enable.
- i_rs  in  READ_PORTS x AW  per-port read address.
- o_rs_data  out  READ_PORTS x XLEN  registered read data.
- o_rs_valid  out  READ_PORTS  high for one cycle, with o_rs_data, for an accepted read.

## Operation
- FSM states: CLEAR and READY. Reset forces CLEAR with the clear counter at 0.
- While i_rst is low: o_ready=0, all o_rs_data=0, all o_rs_valid=0. The array is not written.
- CLEAR, i_rst high:
  - Each edge writes 0 to the entry at the counter, then increments the counter.
  - The edge that writes entry NUM_REGS-1 moves the FSM to READY and sets o_ready=1.
  - i_we and i_re are ignored; o_rs_valid stays 0.
- Reset asserted mid-CLEAR restarts the sequence at entry 0.
- Reset asserted in READY returns the FSM to CLEAR.
- READY, write port p: the entry at i_rd[p] is written when i_we[p]=1, i_rd[p] < NUM_REGS and not (ZERO_REG and i_rd[p]==0).
- Both write ports targeting the same address on the same edge: port 1 wins, port 0's write is discarded.
- READY, read port r with i_re[r]=1: on the edge, o_rs_data[r] takes the entry at i_rs[r] and o_rs_valid[r]=1.
- Read port r with i_re[r]=0: o_rs_data[r] holds its previous value and o_rs_valid[r]=0.
- Reads return 0 when i_rs[r] >= NUM_REGS or (ZERO_REG and i_rs[r]==0).
- BYPASS=1: if an effective write to i_rs[r] happens on the same edge, the read returns the winning write's data.
- BYPASS=0: the read returns the pre-write contents (read-first).
- A zero-register write is never effective, so it is never bypassed.
- All read ports are independent; any number may read the same address in one cycle.
- The storage array must be inferable as RAM: no per-entry reset, and clearing is done only by the sequencer.

## Timing
- Read latency: 1 cycle, from address sampled at edge k to data and valid registered at edge k.
- Write latency: data written at edge k is visible to reads sampled at edge k+1. With BYPASS=1 it is also visible at edge k.
- Clear duration: exactly NUM_REGS edges after the first edge that samples i_rst high. o_ready rises on the last of them.
- First request accepted: the edge after o_ready rises.
- Output values while i_rst is low, and on the first cycle after release: o_ready=0, o_rs_data=0, o_rs_valid=0.
- No backpressure: every request issued in READY completes in one cycle.

## Test plan
- Reset low 3 edges, then high: o_ready=0 for 32 edges and rises at the 32nd. Reads of all 32 entries then return 0 with valid=1.
- READY, write x5=0xDEADBEEF at edge k with port 0 reading x5 at edge k:
  - BYPASS=1: 0xDEADBEEF at edge k.
  - BYPASS=0: 0x00000000 at edge k, then 0xDEADBEEF at edge k+1.
- WRITE_PORTS=2, both ports write x7 (port 0 = 0x11, port 1 = 0x22) on the same edge: the next read of x7 returns 0x22.
- Write x0=0xFFFFFFFF with simultaneous and subsequent reads of x0 on all ports: every read returns 0.
- Reset dropped at clear entry 10, released for 5 edges, then dropped again. After the final release, o_ready rises exactly 32 edges later, and previously written x3=0x55 reads back 0.
- i_re[1]=0 after reading x4=0x99, while x4 is rewritten to 0x77: o_rs_data[1] holds 0x99 and o_rs_valid[1]=0.
